serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 8, operand/result width in bits; legal values 2..64.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, operand request.
REQ-006 Port in_ready, output, 1, block can accept operands.
REQ-007 Port bits_a, input, BITWIDTH, minuend.
REQ-008 Port bits_b, input, BITWIDTH, subtrahend.
REQ-009 Port borrow_in, input, 1, incoming borrow.
REQ-010 Port out_valid, output, 1, result available.
REQ-011 Port out_ready, input, 1, consumer accepts result.
REQ-012 Port diff, output, BITWIDTH, result of (bits_a - bits_b - borrow_in) mod 2^BITWIDTH.
REQ-013 Port borrow_out, output, 1, 1 iff unsigned bits_a < bits_b + borrow_in.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE with in_valid=1, the rising edge SHALL capture bits_a, bits_b and borrow_in into internal registers, clear the bit counter and diff, and enter RUN.
REQ-017 In RUN, each edge SHALL process exactly one bit, LSB first, using a 1-bit full subtractor: d = a^b^br; next br = (~a&b)|(~a&br)|(b&br).
REQ-018 Each RUN edge SHALL write d to diff bit [counter], update the borrow register, and increment the counter.
REQ-019 The edge processing bit BITWIDTH-1 SHALL load borrow_out with the final borrow and enter DONE.
REQ-020 Latency: out_valid SHALL rise exactly BITWIDTH edges after the accepting edge.
REQ-021 In DONE, diff and borrow_out SHALL hold stable until an edge with out_ready=1, which SHALL return the block to IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE, and operand inputs SHALL be ignored after capture.
REQ-023 Simultaneous out_ready=1 and in_valid=1 in DONE SHALL NOT accept new operands; acceptance requires a following IDLE cycle.
REQ-024 diff and borrow_out SHALL keep their last values in IDLE until the next acceptance clears diff.
REQ-025 The counter SHALL be $clog2(BITWIDTH) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, in_ready 1, out_valid 0, diff 0, borrow_out 0, counter 0, internal borrow 0.
REQ-027 Reset asserted in RUN or DONE SHALL abandon the operation with no result delivered.
REQ-028 After rst_n deasserts, the first rising edge SHALL accept operands if in_valid=1.

Configuration
REQ-029 Macro SERIAL_SUB_OVERFLOW_EN defined SHALL add output port overflow (1 bit).
REQ-030 With the macro defined, overflow SHALL equal the borrow into bit BITWIDTH-1 XOR the borrow out of it, i.e. signed two's-complement overflow.
REQ-031 overflow SHALL be loaded with borrow_out, held in DONE, and reset to 0.
REQ-032 With the macro undefined, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (BITWIDTH=8)
REQ-033 Basic subtraction: a=0x05, b=0x03, borrow_in=0 -> diff=0x02, borrow_out=0, out_valid rises exactly 8 edges after acceptance.
REQ-034 Underflow: a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1.
REQ-035 Borrow-in: a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0.
REQ-036 Overflow, macro defined: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing operands -> diff, borrow_out and out_valid stay stable, in_ready stays 0; after out_ready=1, IDLE, then the next operands are accepted.
REQ-038 Reset mid-operation: assert rst_n=0 after 3 RUN edges -> outputs immediately reach reset values; after release, a new 0x05-0x03 operation completes correctly.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first subtractor, one bit per clock, valid/ready handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output.
module serial_sub #(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] bits_a,
    input  logic [BITWIDTH-1:0] bits_b,
    input  logic                borrow_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] diff,
    output logic                borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    , output logic              overflow
`endif
);
    localparam int CW = $clog2(BITWIDTH);
    localparam logic [CW-1:0] LAST = CW'(BITWIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [BITWIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  br_q, br_d, bout_q, bout_d;
    logic                  d_bit, br_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic                  ovf_q, ovf_d;
`endif

    assign d_bit  = a_q[cnt_q] ^ b_q[cnt_q] ^ br_q;
    assign br_nxt = (~a_q[cnt_q] & b_q[cnt_q]) | (~a_q[cnt_q] & br_q) | (b_q[cnt_q] & br_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_d     = bits_a;
                b_d     = bits_b;
                br_d    = borrow_in;
                cnt_d   = '0;
                diff_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                diff_d[cnt_q] = d_bit;
                br_d          = br_nxt;
                // counter parks on the last bit instead of wrapping
                cnt_d         = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d   = br_q ^ br_nxt;
`endif
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed-vector bench for serial_sub at BITWIDTH=8.
module tb_serial_sub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] bits_a = '0;
    logic [7:0] bits_b = '0;
    logic       borrow_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       overflow;
`endif
    int total = 0;
    int bad = 0;

    serial_sub #(.BITWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bits_a(bits_a), .bits_b(bits_b), .borrow_in(borrow_in),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic bi);
        chk("ready_before_accept", in_ready, 1);
        in_valid = 1'b1; bits_a = a; bits_b = b; borrow_in = bi;
        tick();
        in_valid = 1'b0; bits_a = 8'hA5; bits_b = 8'h3C; borrow_in = ~bi;
        chk("ready_after_accept", in_ready, 0);
        chk("valid_after_accept", out_valid, 0);
    endtask

    task automatic finish(input string tag, input logic [7:0] ed, input logic eb);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow_out, eb);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_ready", in_ready, 1);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        tick();
        rst_n = 1'b1;

        start(8'h05, 8'h03, 1'b0);
        finish("basic", 8'h02, 1'b0);
        release_out();
        chk("idle_hold_diff", diff, 8'h02);

        start(8'h00, 8'h01, 1'b0);
        finish("underflow", 8'hFF, 1'b1);
        release_out();

        start(8'h10, 8'h0F, 1'b1);
        finish("borrow_in", 8'h00, 1'b0);
        release_out();

        start(8'h80, 8'h01, 1'b0);
        finish("ovf_pos", 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf_pos_flag", overflow, 1);
`endif
        release_out();

        start(8'h7F, 8'hFF, 1'b0);
        finish("ovf_neg", 8'h80, 1'b1);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf_neg_flag", overflow, 1);
`endif
        release_out();

        // backpressure with DONE held and new operands waving at the input
        start(8'h00, 8'h01, 1'b0);
        finish("bp", 8'hFF, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bits_a = 8'(i * 37); bits_b = 8'(i * 11 + 1); borrow_in = i[0];
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_diff", diff, 8'hFF);
            chk("bp_borrow", borrow_out, 1);
        end
        bits_a = 8'h10; bits_b = 8'h0F; borrow_in = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_no_accept_ready", in_ready, 1);
        chk("bp_no_accept_valid", out_valid, 0);
        chk("bp_idle_diff", diff, 8'hFF);
        tick();
        in_valid = 1'b0;
        chk("bp_next_accept", in_ready, 0);
        finish("bp_next", 8'h00, 1'b0);
        release_out();

        // reset after three RUN edges
        start(8'h05, 8'h03, 1'b0);
        tick(); tick(); tick();
        chk("mid_diff_partial", diff, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("mid_rst_ovf", overflow, 0);
`endif
        tick();
        rst_n = 1'b1;
        start(8'h05, 8'h03, 1'b0);
        finish("after_rst", 8'h02, 1'b0);
        release_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
